// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder: reads a stored frame out of a word-addressed RAM with a
// registered output and replays it as a valid-qualified packed pixel stream.
// Each frame is preceded by a one-cycle kernel reset pulse. The frame is paced
// by a start/pause handshake, and downstream has no backpressure.
module pixel_stream_feeder #(
  parameter int DataWidth = 16,
  parameter int Row       = 4,
  parameter int Col       = 4,
  parameter int Pwr       = 2,
  parameter int AddrWidth = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [AddrWidth-1:0]       i_base_addr,
  input  logic                       i_pause,
  output logic                       o_rd_en,
  output logic [AddrWidth-1:0]       o_rd_addr,
  input  logic [DataWidth*Pwr-1:0]   i_rd_data,
  output logic [DataWidth*Pwr-1:0]   o_pixel_data,
  output logic                       o_pixel_data_valid,
  output logic                       o_kernel_reset,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NW    = (Row * Col) / Pwr;
  localparam int CntW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int BeatW = DataWidth * Pwr;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KRST,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [AddrWidth-1:0]   base_q, base_d;
  logic                   rd_en;

  logic                   vld_p0_q, vld_p0_d;
  logic                   vld_p1_q, vld_p1_d;
  logic [BeatW-1:0]       pix_p1_q, pix_p1_d;

  // Frame sequencing: next state, word counter and read strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_base_addr;
          cnt_d   = '0;
          state_d = S_KRST;
        end
      end
      S_KRST: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // A paused cycle issues nothing and holds the word counter.
        if (!i_pause) begin
          rd_en = 1'b1;
          if (cnt_q == CntW'(NW - 1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      S_DRAIN: begin
        // The last read has left stage 0 once vld_p0 drops; the beat it
        // produces is on the output this cycle.
        if (!vld_p0_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers for the frame sequencer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Read-return pipeline: stage 0 marks the cycle the RAM word arrives,
  // stage 1 is the registered beat; the beat holds its value between valids.
  always_comb begin
    vld_p0_d = rd_en;
    vld_p1_d = vld_p0_q;
    pix_p1_d = vld_p0_q ? i_rd_data : pix_p1_q;
  end

  // Pipeline registers; cleared on reset so no stale beat follows it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      pix_p1_q <= '0;
    end else begin
      // stage 0 -> stage 1
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      pix_p1_q <= pix_p1_d;
    end
  end

  assign o_rd_en            = rd_en;
  assign o_rd_addr          = rd_en ? (base_q + AddrWidth'(cnt_q)) : '0;
  assign o_pixel_data       = pix_p1_q;
  assign o_pixel_data_valid = vld_p1_q;
  assign o_kernel_reset     = (state_q == S_KRST);
  assign o_busy             = (state_q != S_IDLE);
  assign o_done             = (state_q == S_DONE);

endmodule
